alu_operand_stage: RTL

Issue stage directly upstream of the integer ALU. Decodes RV32I OP, OP-IMM, LUI and AUIPC instructions into the ALU's 4-bit opcode and its A/B operands, then registers the result. Uses a valid/ready handshake on both sides with a 2-entry skid buffer, so it sustains one instruction per cycle under backpressure.

---
 rtl/alu_operand_stage.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - RV32I OP/OP-IMM/LUI/AUIPC decode into ALU operands with 2-entry skid buffer
module alu_operand_stage #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [width-1:0] in_pc,
  input  logic [width-1:0] in_rs1,
  input  logic [width-1:0] in_rs2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_opcode,
  output logic [width-1:0] out_a,
  output logic [width-1:0] out_b,
  output logic [4:0]       out_rd,
  output logic             out_wen,
  output logic             out_illegal
);

  localparam logic [6:0] major_op     = 7'b0110011;
  localparam logic [6:0] major_op_imm = 7'b0010011;
  localparam logic [6:0] major_lui    = 7'b0110111;
  localparam logic [6:0] major_auipc  = 7'b0010111;

  localparam logic [6:0] funct7_zero = 7'h00;
  localparam logic [6:0] funct7_alt  = 7'h20;

  // Instruction fields
  logic [6:0] major;
  logic [2:0] f3;
  logic       b30;
  logic [6:0] funct7;
  logic [4:0] rd_field;

  assign major    = in_instr[6:0];
  assign f3       = in_instr[14:12];
  assign b30      = in_instr[30];
  assign funct7   = in_instr[31:25];
  assign rd_field = in_instr[11:7];

  // The rs1/rs2 register specifiers are resolved upstream; only their values arrive here.
  logic unused_rs_fields;
  assign unused_rs_fields = &{1'b0, in_instr[19:15]};

  // Decoded entry, before registering
  logic [3:0]       dec_opcode;
  logic [width-1:0] dec_a;
  logic [width-1:0] dec_b;
  logic             dec_legal;
  logic             dec_wen;

  logic [width-1:0] imm_i;
  logic [width-1:0] imm_u;
  logic [width-1:0] shamt;

  assign imm_i = width'($signed(in_instr[31:20]));
  assign imm_u = width'($signed({in_instr[31:12], 12'h000}));
  assign shamt = width'(in_instr[24:20]);

  // Combinational decode of the presented instruction
  always_comb begin
    dec_opcode = 4'b0000;
    dec_a      = '0;
    dec_b      = '0;
    dec_legal  = 1'b0;
    unique case (major)
      major_op: begin
        dec_opcode = {f3, b30};
        dec_a      = in_rs1;
        dec_b      = in_rs2;
        // Only ADD/SUB and SRL/SRA have an alternate (0x20) encoding
        dec_legal  = (funct7 == funct7_zero) ||
                     ((funct7 == funct7_alt) && ((f3 == 3'b000) || (f3 == 3'b101)));
      end
      major_op_imm: begin
        dec_a = in_rs1;
        if ((f3 == 3'b001) || (f3 == 3'b101)) begin
          dec_opcode = {f3, b30};
          dec_b      = shamt;
          if (f3 == 3'b001) begin
            dec_legal = (funct7 == funct7_zero);
          end else begin
            dec_legal = (funct7 == funct7_zero) || (funct7 == funct7_alt);
          end
        end else begin
          // b30 belongs to the immediate here, so ADDI must never turn into SUB
          dec_opcode = {f3, 1'b0};
          dec_b      = imm_i;
          dec_legal  = 1'b1;
        end
      end
      major_lui: begin
        dec_opcode = 4'b0000;
        dec_a      = '0;
        dec_b      = imm_u;
        dec_legal  = 1'b1;
      end
      major_auipc: begin
        dec_opcode = 4'b0000;
        dec_a      = in_pc;
        dec_b      = imm_u;
        dec_legal  = 1'b1;
      end
      default: begin
        dec_opcode = 4'b0000;
        dec_a      = '0;
        dec_b      = '0;
        dec_legal  = 1'b0;
      end
    endcase
  end

  assign dec_wen = dec_legal && (rd_field != 5'd0);

  // Pipeline storage: main register drives the outputs, skid catches one entry under stall
  logic             main_valid;
  logic             skid_valid;
  logic [3:0]       skid_opcode;
  logic [width-1:0] skid_a;
  logic [width-1:0] skid_b;
  logic [4:0]       skid_rd;
  logic             skid_wen;
  logic             skid_illegal;

  logic in_fire;
  logic main_load;
  logic skid_valid_nxt;

  assign in_fire   = in_valid && in_ready;
  // Main may be replaced when empty or when its current entry leaves this cycle
  assign main_load = !main_valid || out_ready;
  // Skid always drains into main when main can load; otherwise it captures any accepted input
  assign skid_valid_nxt = main_load ? 1'b0 : (skid_valid || in_fire);

  assign out_valid = main_valid;

  // Main register: refill from skid first to keep FIFO order, else from decode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid  <= 1'b0;
      out_opcode  <= 4'b0000;
      out_a       <= '0;
      out_b       <= '0;
      out_rd      <= 5'd0;
      out_wen     <= 1'b0;
      out_illegal <= 1'b0;
    end else if (main_load) begin
      if (skid_valid) begin
        main_valid  <= 1'b1;
        out_opcode  <= skid_opcode;
        out_a       <= skid_a;
        out_b       <= skid_b;
        out_rd      <= skid_rd;
        out_wen     <= skid_wen;
        out_illegal <= skid_illegal;
      end else if (in_fire) begin
        main_valid  <= 1'b1;
        out_opcode  <= dec_opcode;
        out_a       <= dec_a;
        out_b       <= dec_b;
        out_rd      <= rd_field;
        out_wen     <= dec_wen;
        out_illegal <= !dec_legal;
      end else begin
        main_valid <= 1'b0;
      end
    end
  end

  // Skid register: holds an entry accepted while main is occupied and stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_valid   <= 1'b0;
      skid_opcode  <= 4'b0000;
      skid_a       <= '0;
      skid_b       <= '0;
      skid_rd      <= 5'd0;
      skid_wen     <= 1'b0;
      skid_illegal <= 1'b0;
    end else begin
      skid_valid <= skid_valid_nxt;
      if (!main_load && in_fire) begin
        skid_opcode  <= dec_opcode;
        skid_a       <= dec_a;
        skid_b       <= dec_b;
        skid_rd      <= rd_field;
        skid_wen     <= dec_wen;
        skid_illegal <= !dec_legal;
      end
    end
  end

  // Registered ready: mirrors the next skid occupancy so it never depends on out_ready combinationally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready <= 1'b1;
    end else begin
      in_ready <= !skid_valid_nxt;
    end
  end

endmodule
